// File: rtl/lsu_mem_unit.sv
// Multi-cycle load/store unit: one access in flight; B/H/W/D loads and stores on a valid/ready memory port.
// Latency: resp_valid 2 cycles after acceptance (1 on error paths); held until resp_ready, stalls via mem_ready/mem_rvalid.
module lsu_mem_unit #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [1:0]          resp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_nxt_state;
    logic                r_drop;
    logic [TW-1:0]       r_timer;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN-1:0]     r_resp_rdata;
    logic [1:0]          r_resp_err;

    logic                w_accept;
    logic                w_req_illegal;
    logic                w_req_misal;
    logic                w_timeout;
    logic                w_set_resp;
    logic                w_set_drop;
    logic                w_clr_timer;
    logic [1:0]          w_nxt_err;
    logic [XLEN-1:0]     w_nxt_rdata;
    logic [OFFW-1:0]     w_off;
    logic [OFFW+2:0]     w_shamt;
    logic [XLEN-1:0]     w_sh;
    logic [XLEN-1:0]     w_keep;
    logic                w_sb;
    logic [XLEN-1:0]     w_ld_data;
    logic [NB-1:0]       w_bmask;

    assign req_ready = (r_state == S_IDLE) && !r_drop && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_timeout = (TIMEOUT != 0) && (r_timer >= TW'(TIMEOUT - 1));

    assign w_off   = r_addr[OFFW-1:0];
    assign w_shamt = {w_off, 3'b000};

    assign mem_valid  = (r_state == S_REQ);
    assign mem_we     = r_we;
    assign mem_addr   = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign mem_wdata  = r_wdata << w_shamt;
    assign mem_wmask  = r_we ? (w_bmask << w_off) : {NB{1'b1}};
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    // Request legality is judged on the live inputs so errors go straight to RESP.
    always_comb begin
        w_req_illegal = (req_we && req_funct3[2])
                     || ((XLEN == 32) && (req_funct3[1:0] == 2'd3))
                     || ((XLEN == 32) && !req_we && (req_funct3 == 3'b110));
        case (req_funct3[1:0])
            2'd1:    w_req_misal = req_addr[0];
            2'd2:    w_req_misal = |req_addr[1:0];
            2'd3:    w_req_misal = |req_addr[2:0];
            default: w_req_misal = 1'b0;
        endcase
    end

    always_comb begin
        w_sh = mem_rdata >> w_shamt;
        for (int i = 0; i < XLEN; i++) begin
            w_keep[i] = (i < (8 << r_funct3[1:0]));
        end
        for (int i = 0; i < NB; i++) begin
            w_bmask[i] = (i < (1 << r_funct3[1:0]));
        end
        case (r_funct3[1:0])
            2'd0:    w_sb = w_sh[7];
            2'd1:    w_sb = w_sh[15];
            2'd2:    w_sb = w_sh[31];
            default: w_sb = w_sh[XLEN-1];
        endcase
        w_ld_data = (w_sh & w_keep) | (~w_keep & {XLEN{w_sb & ~r_funct3[2]}});
    end

    always_comb begin
        w_nxt_state = r_state;
        w_set_resp  = 1'b0;
        w_set_drop  = 1'b0;
        w_clr_timer = 1'b0;
        w_nxt_err   = 2'd0;
        w_nxt_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_illegal) begin
                        w_nxt_state = S_RESP;
                        w_set_resp  = 1'b1;
                        w_nxt_err   = 2'd3;
                    end else if (w_req_misal) begin
                        w_nxt_state = S_RESP;
                        w_set_resp  = 1'b1;
                        w_nxt_err   = 2'd1;
                    end else begin
                        w_nxt_state = S_REQ;
                        w_clr_timer = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        w_nxt_state = S_RESP;
                        w_set_resp  = 1'b1;
                        w_nxt_rdata = r_we ? '0 : w_ld_data;
                    end else begin
                        w_nxt_state = S_WAIT;
                    end
                end else if (w_timeout) begin
                    w_nxt_state = S_RESP;
                    w_set_resp  = 1'b1;
                    w_nxt_err   = 2'd2;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_nxt_state = S_RESP;
                    w_set_resp  = 1'b1;
                    w_nxt_rdata = r_we ? '0 : w_ld_data;
                end else if (w_timeout) begin
                    // Memory still owes us a beat; swallow it later.
                    w_nxt_state = S_RESP;
                    w_set_resp  = 1'b1;
                    w_set_drop  = 1'b1;
                    w_nxt_err   = 2'd2;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_nxt_state = S_IDLE;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_drop       <= 1'b0;
            r_timer      <= '0;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 2'd0;
        end else begin
            r_state <= w_nxt_state;
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (w_clr_timer) begin
                r_timer <= '0;
            end else if ((r_state == S_REQ || r_state == S_WAIT) && !w_timeout) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_set_drop) begin
                r_drop <= 1'b1;
            end else if (r_drop && mem_rvalid) begin
                r_drop <= 1'b0;
            end
            if (w_set_resp) begin
                r_resp_rdata <= w_nxt_rdata;
                r_resp_err   <= w_nxt_err;
            end else if (r_state == S_RESP && resp_ready) begin
                r_resp_rdata <= '0;
                r_resp_err   <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Directed bench for lsu_mem_unit (XLEN=64, TIMEOUT=16) with a response scoreboard queue.
module tb_lsu_mem_unit;
    localparam int XLEN = 64;
    localparam int AW   = 64;
    localparam int TO   = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_ready, req_we;
    logic [2:0]      req_funct3;
    logic [AW-1:0]   req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid, resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_err;
    logic            mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata, mem_rdata;
    logic [7:0]      mem_wmask;

    always #5 clk = ~clk;

    lsu_mem_unit #(.XLEN(XLEN), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic [63:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_resp(input logic [63:0] d, input logic [1:0] e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        sb_q.push_back(x);
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        chk("req_ready_at_send", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int maxc, output int lat);
        exp_t e;
        lat = 1;
        while (!resp_valid && lat < maxc) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            chk({tag, "_resp_timeout"}, 64'(resp_valid), 64'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_err"}, 64'(resp_err), 64'(e.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] t_addr [5] = '{64'h80000003, 64'h80000003, 64'h80000002, 64'h80000000, 64'h80000000};
        logic [2:0]  t_f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110};
        logic [63:0] t_exp  [5] = '{64'hFFFFFFFFFFFFFF89, 64'h0000000000000089,
                                    64'hFFFFFFFFFFFF89AB, 64'hFFFFFFFF89ABCDEF,
                                    64'h0000000089ABCDEF};
        int lat;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // Loads with memory answering in the same cycle as acceptance of the bus request.
        mem_rdata = 64'h0123456789ABCDEF; mem_ready = 1'b1; mem_rvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_resp(t_exp[i], 2'd0);
            send(1'b0, t_f3[i], t_addr[i], 64'd0);
            chk("ld_mem_valid", 64'(mem_valid), 64'd1);
            chk("ld_mem_addr", mem_addr, 64'h80000000);
            chk("ld_mem_wmask", 64'(mem_wmask), 64'hFF);
            chk("ld_mem_we", 64'(mem_we), 64'd0);
            chk("ld_resp_early", 64'(resp_valid), 64'd0);
            wait_resp("ld", 8, lat);
            chk("ld_latency", 64'(lat), 64'd2);
            @(negedge clk);
        end

        // Store half with a separate write acknowledge.
        mem_rvalid = 1'b0;
        expect_resp(64'd0, 2'd0);
        send(1'b1, 3'b001, 64'h80000006, 64'hDEADBEEFCAFEBABE);
        chk("sh_mem_we", 64'(mem_we), 64'd1);
        chk("sh_mem_wmask", 64'(mem_wmask), 64'hC0);
        chk("sh_mem_wdata_hi", 64'(mem_wdata[63:48]), 64'hBABE);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("sh_wait_mem_valid", 64'(mem_valid), 64'd0);
        mem_rvalid = 1'b1;
        wait_resp("sh", 8, lat);
        mem_rvalid = 1'b0;
        @(negedge clk);

        // Error paths: misaligned LW, illegal store with funct3[2] set.
        expect_resp(64'd0, 2'd1);
        send(1'b0, 3'b010, 64'h80000002, 64'd0);
        chk("mis_mem_valid", 64'(mem_valid), 64'd0);
        wait_resp("mis", 8, lat);
        chk("mis_latency", 64'(lat), 64'd1);
        @(negedge clk);
        expect_resp(64'd0, 2'd3);
        send(1'b1, 3'b111, 64'h80000000, 64'h55);
        chk("ill_mem_valid", 64'(mem_valid), 64'd0);
        wait_resp("ill", 8, lat);
        chk("ill_latency", 64'(lat), 64'd1);
        @(negedge clk);

        // Memory stall of 3 cycles, then response held by resp_ready low.
        mem_rdata = 64'h1122334455667788;
        expect_resp(64'h1122334455667788, 2'd0);
        send(1'b0, 3'b011, 64'h80000010, 64'd0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_mem_valid", 64'(mem_valid), 64'd1);
            chk("stall_mem_addr", mem_addr, 64'h80000010);
            chk("stall_mem_wmask", 64'(mem_wmask), 64'hFF);
        end
        mem_ready = 1'b1; mem_rvalid = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        wait_resp("stall", 8, lat);
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hold_resp_valid", 64'(resp_valid), 64'd1);
            chk("hold_resp_rdata", resp_rdata, 64'h1122334455667788);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_released", 64'(resp_valid), 64'd0);

        // Timeout with mem_ready never given.
        expect_resp(64'd0, 2'd2);
        send(1'b0, 3'b011, 64'h80000020, 64'd0);
        wait_resp("to_req", 40, lat);
        chk("to_req_latency", 64'(lat), 64'(TO + 1));
        @(negedge clk);
        chk("to_req_ready", 64'(req_ready), 64'd1);

        // Timeout after acceptance: stale beat must be dropped before the next access.
        expect_resp(64'd0, 2'd2);
        mem_ready = 1'b1;
        send(1'b0, 3'b011, 64'h80000028, 64'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        wait_resp("to_wait", 40, lat);
        chk("to_wait_latency", 64'(lat), 64'(TO));
        @(negedge clk);
        chk("drop_req_ready0", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("drop_req_ready1", 64'(req_ready), 64'd0);
        mem_rdata = 64'hDEADDEADDEADDEAD; mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("drop_cleared", 64'(req_ready), 64'd1);
        chk("drop_no_resp", 64'(resp_valid), 64'd0);
        mem_rdata = 64'hA5A55A5A0F0FF0F0; mem_ready = 1'b1; mem_rvalid = 1'b1;
        expect_resp(64'hA5A55A5A0F0FF0F0, 2'd0);
        send(1'b0, 3'b011, 64'h80000008, 64'd0);
        wait_resp("post_drop", 8, lat);
        chk("post_drop_latency", 64'(lat), 64'd2);
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);

        // Reset while waiting on memory abandons the access.
        mem_ready = 1'b1;
        send(1'b0, 3'b011, 64'h80000018, 64'd0);
        chk("rst6_mem_valid_req", 64'(mem_valid), 64'd1);
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst6_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst6_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst6_req_ready_hi", 64'(req_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst6_req_ready", 64'(req_ready), 64'd1);
        mem_rdata = 64'h8877665544332211; mem_ready = 1'b1; mem_rvalid = 1'b1;
        expect_resp(64'h8877665544332211, 2'd0);
        send(1'b0, 3'b011, 64'h80000008, 64'd0);
        wait_resp("post_rst", 8, lat);
        chk("post_rst_latency", 64'(lat), 64'd2);
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
